// File: rtl/wb_timer.sv
// Wishbone timer/counter: 32-bit up/down count with prescaler, reload, sticky expiry flag and level irq.
// Ack is registered one cycle after the request and never stalls; back-to-back requests complete every 2 cycles.
module wb_timer #(
  parameter int AW  = 32,
  parameter int PSW = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [3:0]    wb_sel_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          irq_o
);

  logic           en, oneshot, up, irq_en, exp_flag;
  logic [PSW-1:0] prescale, pc;
  logic [31:0]    value, reload;

  logic           en_n, oneshot_n, up_n, irq_en_n, exp_n;
  logic [PSW-1:0] prescale_n, pc_n;
  logic [31:0]    value_n, reload_n;

  logic           req, wr, wr_value, tick, hit, expire;
  logic [1:0]     adr;
  logic [31:0]    cfg_rd, rd_dat;
  logic           unused_adr;

  assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr       = req & wb_we_i;
  assign adr      = wb_adr_i[3:2];
  assign wr_value = wr && (adr == 2'd1);
  assign tick     = en && (pc == prescale);
  assign hit      = up ? (value == reload) : (value == 32'd0);
  // A bus write to VALUE pre-empts the count, so it also suppresses expiry.
  assign expire   = tick && hit && !wr_value;
  assign irq_o    = exp_flag & irq_en;
  assign unused_adr = ^{wb_adr_i[AW-1:4], wb_adr_i[1:0]};

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++)
      if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  always_comb begin
    cfg_rd = '0;
    cfg_rd[0] = en;
    cfg_rd[1] = oneshot;
    cfg_rd[2] = up;
    cfg_rd[3] = irq_en;
    cfg_rd[8 +: PSW] = prescale;
    case (adr)
      2'd0:    rd_dat = cfg_rd;
      2'd1:    rd_dat = value;
      2'd2:    rd_dat = reload;
      default: rd_dat = {31'd0, exp_flag};
    endcase
  end

  always_comb begin
    en_n       = en;
    oneshot_n  = oneshot;
    up_n       = up;
    irq_en_n   = irq_en;
    prescale_n = prescale;
    value_n    = value;
    reload_n   = reload;
    exp_n      = exp_flag;

    if (wr_value)
      value_n = lane_merge(value, wb_dat_i, wb_sel_i);
    else if (tick) begin
      if (up)
        value_n = hit ? 32'd0 : value + 32'd1;
      else
        value_n = hit ? reload : value - 32'd1;
    end

    if (expire && oneshot) en_n = 1'b0;
    // Bus bytes override the oneshot auto-disable on the same edge.
    if (wr && adr == 2'd0 && wb_sel_i[0]) begin
      en_n      = wb_dat_i[0];
      oneshot_n = wb_dat_i[1];
      up_n      = wb_dat_i[2];
      irq_en_n  = wb_dat_i[3];
    end
    if (wr && adr == 2'd0 && wb_sel_i[1]) prescale_n = wb_dat_i[8 +: PSW];
    if (wr && adr == 2'd2) reload_n = lane_merge(reload, wb_dat_i, wb_sel_i);
    if (wr && adr == 2'd3 && wb_sel_i[0] && wb_dat_i[0]) exp_n = 1'b0;
    if (expire) exp_n = 1'b1;

    // pc sits at 0 whenever disabled, so a 0->1 enable always restarts from 0.
    pc_n = (!en || !en_n || tick) ? '0 : pc + 1'b1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      en       <= 1'b0;
      oneshot  <= 1'b0;
      up       <= 1'b0;
      irq_en   <= 1'b0;
      prescale <= '0;
      pc       <= '0;
      value    <= '0;
      reload   <= '0;
      exp_flag <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      en       <= en_n;
      oneshot  <= oneshot_n;
      up       <= up_n;
      irq_en   <= irq_en_n;
      prescale <= prescale_n;
      pc       <= pc_n;
      value    <= value_n;
      reload   <= reload_n;
      exp_flag <= exp_n;
      wb_ack_o <= req;
      if (req && !wb_we_i) wb_dat_o <= rd_dat;
    end
  end

endmodule
